// File: rtl/reg_host_if.sv
// rtl/reg_host_if.sv - host command decoder driving the LED controller register file
module reg_host_if (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_active_i,
  input  logic       byte_vld_i,
  input  logic [7:0] byte_data_i,
  output logic [2:0] reg_rd_addr_o,
  input  logic [7:0] reg_rd_data_i,
  output logic       reg_wr_en_o,
  output logic [2:0] reg_wr_addr_o,
  output logic [7:0] reg_wr_data_o,
  output logic [7:0] tx_byte_o,
  output logic       tx_load_o,
  output logic       cmd_err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t     r_state;
  logic [2:0] r_addr;
  logic       r_fetch;
  logic       w_accept;

  assign w_accept = byte_vld_i & frame_active_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_addr        <= 3'd0;
      r_fetch       <= 1'b0;
      reg_rd_addr_o <= 3'd0;
      reg_wr_en_o   <= 1'b0;
      reg_wr_addr_o <= 3'd0;
      reg_wr_data_o <= 8'd0;
      tx_byte_o     <= 8'd0;
      tx_load_o     <= 1'b0;
      cmd_err_o     <= 1'b0;
    end else begin
      reg_wr_en_o <= 1'b0;
      cmd_err_o   <= 1'b0;
      r_fetch     <= 1'b0;
      // A fetch scheduled last edge completes even if the frame has just ended.
      tx_load_o   <= r_fetch;
      if (r_fetch) begin
        tx_byte_o <= reg_rd_data_i;
      end

      if (!frame_active_i) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: r_state <= CMD;
          CMD: begin
            if (w_accept) begin
              if (byte_data_i[6:3] != 4'b0000) begin
                r_state   <= ERR;
                cmd_err_o <= 1'b1;
              end else if (byte_data_i[7]) begin
                r_state <= WRITE;
                r_addr  <= byte_data_i[2:0];
              end else begin
                r_state       <= READ;
                reg_rd_addr_o <= byte_data_i[2:0];
                r_fetch       <= 1'b1;
              end
            end
          end
          WRITE: begin
            if (w_accept) begin
              // Host addresses 0 and 1 are read-only; the byte is dropped.
              if (r_addr >= 3'd2) begin
                reg_wr_en_o   <= 1'b1;
                reg_wr_addr_o <= r_addr - 3'd2;
                reg_wr_data_o <= byte_data_i;
              end
              r_addr <= r_addr + 3'd1;
            end
          end
          READ: begin
            if (w_accept) begin
              reg_rd_addr_o <= reg_rd_addr_o + 3'd1;
              r_fetch       <= 1'b1;
            end
          end
          default: r_state <= ERR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_host_if.sv
// tb/tb_reg_host_if.sv - directed self-checking bench for reg_host_if
module tb_reg_host_if;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       frame_active_i;
  logic       byte_vld_i;
  logic [7:0] byte_data_i;
  logic [2:0] reg_rd_addr_o;
  logic [7:0] reg_rd_data_i;
  logic       reg_wr_en_o;
  logic [2:0] reg_wr_addr_o;
  logic [7:0] reg_wr_data_o;
  logic [7:0] tx_byte_o;
  logic       tx_load_o;
  logic       cmd_err_o;

  logic [7:0] mem [8];
  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  assign reg_rd_data_i = mem[reg_rd_addr_o];

  reg_host_if dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .frame_active_i (frame_active_i),
    .byte_vld_i     (byte_vld_i),
    .byte_data_i    (byte_data_i),
    .reg_rd_addr_o  (reg_rd_addr_o),
    .reg_rd_data_i  (reg_rd_data_i),
    .reg_wr_en_o    (reg_wr_en_o),
    .reg_wr_addr_o  (reg_wr_addr_o),
    .reg_wr_data_o  (reg_wr_data_o),
    .tx_byte_o      (tx_byte_o),
    .tx_load_o      (tx_load_o),
    .cmd_err_o      (cmd_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] a, input logic [7:0] d);
    chk(tag, {20'd0, reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o}, {20'd0, 1'b1, a, d});
  endtask

  // Drive one cycle of byte inputs at the falling edge; outputs read right after
  // reflect the byte driven on the previous call.
  task automatic cyc(input logic v, input logic [7:0] d);
    @(negedge clk_i);
    byte_vld_i  = v;
    byte_data_i = d;
  endtask

  task automatic start_frame();
    @(negedge clk_i);
    frame_active_i = 1'b1;
    byte_vld_i     = 1'b0;
  endtask

  task automatic end_frame();
    @(negedge clk_i);
    frame_active_i = 1'b0;
    byte_vld_i     = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    mem[0] = 8'h00; mem[1] = 8'h5A; mem[2] = 8'h11; mem[3] = 8'h22;
    mem[4] = 8'h33; mem[5] = 8'h44; mem[6] = 8'h55; mem[7] = 8'h66;
    rst_i = 1'b1; frame_active_i = 1'b0; byte_vld_i = 1'b0; byte_data_i = 8'h00;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("reset_idle_outputs",
          {5'd0, reg_rd_addr_o, reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o, tx_byte_o, tx_load_o, cmd_err_o},
          32'd0);
    end

    // Write burst from host address 2
    start_frame();
    cyc(1, 8'h82);
    cyc(1, 8'h10); chk("wb_cmd_no_strobe", reg_wr_en_o, 0);
    cyc(1, 8'h20); chk_wr("wb_byte0", 3'd0, 8'h10);
    cyc(1, 8'h30); chk_wr("wb_byte1", 3'd1, 8'h20);
    cyc(0, 8'h00); chk_wr("wb_byte2", 3'd2, 8'h30);
    cyc(0, 8'h00); chk("wb_end_no_strobe", reg_wr_en_o, 0);
    end_frame();

    // Start at 7, wrap through read-only addresses 0 and 1
    start_frame();
    cyc(1, 8'h87);
    cyc(1, 8'hAA); chk("wr_cmd_no_strobe", reg_wr_en_o, 0);
    cyc(1, 8'hBB); chk_wr("wr_addr7", 3'd5, 8'hAA);
    cyc(1, 8'hCC); chk("wr_addr0_dropped", reg_wr_en_o, 0);
    cyc(1, 8'hDD); chk("wr_addr1_dropped", reg_wr_en_o, 0);
    cyc(0, 8'h00); chk_wr("wr_addr2", 3'd0, 8'hDD);
    cyc(0, 8'h00); chk("wr_end_no_strobe", reg_wr_en_o, 0);
    end_frame();

    // Read burst from address 1 with back-to-back dummy bytes
    start_frame();
    cyc(1, 8'h01);
    cyc(1, 8'hFF); chk("rd_addr_a", reg_rd_addr_o, 1); chk("rd_load_early", tx_load_o, 0);
    cyc(1, 8'hFF); chk("rd_addr_b", reg_rd_addr_o, 2); chk("rd_tx0", {tx_load_o, tx_byte_o}, {1'b1, 8'h5A});
    cyc(0, 8'h00); chk("rd_addr_c", reg_rd_addr_o, 3); chk("rd_tx1", {tx_load_o, tx_byte_o}, {1'b1, 8'h11});
    cyc(0, 8'h00); chk("rd_tx2", {tx_load_o, tx_byte_o}, {1'b1, 8'h22});
    chk("rd_no_write", reg_wr_en_o, 0);
    cyc(0, 8'h00); chk("rd_tx_hold", {tx_load_o, tx_byte_o}, {1'b0, 8'h22});
    end_frame();

    // Illegal command, then a normal frame
    start_frame();
    cyc(1, 8'h48);
    cyc(1, 8'h82); chk("err_pulse", cmd_err_o, 1);
    cyc(1, 8'h55); chk("err_single", cmd_err_o, 0); chk("err_no_wr_a", reg_wr_en_o, 0);
    cyc(0, 8'h00); chk("err_no_strobes", {reg_wr_en_o, tx_load_o, cmd_err_o}, 0);
    end_frame();
    start_frame();
    cyc(1, 8'h83);
    cyc(1, 8'h77);
    cyc(0, 8'h00); chk_wr("after_err_write", 3'd1, 8'h77);
    end_frame();

    // Frame drop mid-burst; byte in the falling cycle is ignored
    start_frame();
    cyc(1, 8'h82);
    cyc(1, 8'h01);
    cyc(1, 8'h02); chk_wr("drop_byte0", 3'd0, 8'h01);
    @(negedge clk_i);
    frame_active_i = 1'b0; byte_vld_i = 1'b1; byte_data_i = 8'h03;
    chk_wr("drop_inflight", 3'd1, 8'h02);
    cyc(0, 8'h00); chk("drop_no_more", reg_wr_en_o, 0);
    cyc(0, 8'h00); chk("drop_still_none", reg_wr_en_o, 0);
    start_frame();
    cyc(1, 8'h84);
    cyc(1, 8'h99);
    cyc(0, 8'h00); chk_wr("drop_next_cmd", 3'd2, 8'h99);
    end_frame();

    // Asynchronous reset mid-burst
    start_frame();
    cyc(1, 8'h82);
    cyc(1, 8'h10);
    cyc(1, 8'h20); chk_wr("rst_pre_write", 3'd0, 8'h10);
    #1 rst_i = 1'b1; frame_active_i = 1'b0; byte_vld_i = 1'b0;
    #1 chk("rst_async_clear",
          {5'd0, reg_rd_addr_o, reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o, tx_byte_o, tx_load_o, cmd_err_o},
          32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    cyc(0, 8'h00); chk("rst_no_strobe", reg_wr_en_o, 0);
    start_frame();
    cyc(1, 8'h85);
    cyc(1, 8'h42);
    cyc(0, 8'h00); chk_wr("rst_next_cmd", 3'd3, 8'h42);
    end_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
